mmio_controller: RTL and testbench



---
 rtl/mmio_controller.sv | 139 +++++++++++++
 tb/tb_mmio_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mmio_controller.sv
// CPU memory/IO bridge: word RAM at 0, LED/switch/edge-capture/irq-mask registers at IO_BASE.
// Registered reads with one-cycle ready; optional switch debounce via `define SWITCH_DEBOUNCE_EN.
module mmio_controller #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 16,
  parameter int                    RAM_DEPTH       = 1024,
  parameter int                    NUM_LEDS        = 4,
  parameter int                    NUM_SWITCHES    = 4,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE         = 16'hFF00,
  parameter int                    DEBOUNCE_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_fromCPU,
  input  logic                    we,
  input  logic                    re,
  output logic [DATA_WIDTH-1:0]   data_toCPU,
  output logic                    ready,
  output logic [NUM_LEDS-1:0]     LEDs,
  input  logic [NUM_SWITCHES-1:0] switches,
  output logic                    sw_irq
);

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] RAM_END = ADDR_WIDTH'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] A_LED   = IO_BASE;
  localparam logic [ADDR_WIDTH-1:0] A_STAT  = IO_BASE + ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_CAP   = IO_BASE + ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_MASK  = IO_BASE + ADDR_WIDTH'(3);
`ifdef SWITCH_DEBOUNCE_EN
  localparam int WARMUP = DEBOUNCE_CYCLES + 3;
`else
  localparam int WARMUP = 3;
`endif
  // Sized for the longer (debounced) warm-up so both builds share one counter.
  localparam int WARM_W = $clog2(DEBOUNCE_CYCLES + 4);

  logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    ready_q;
  logic [NUM_LEDS-1:0]     leds_q;
  logic [NUM_SWITCHES-1:0] sync_q, status_q, status_prev_q, capture_q, mask_q;
  logic [WARM_W-1:0]       warm_q;

  logic                    ram_hit, warm_done;
  logic                    wr_led, wr_cap, wr_mask;
  logic [RAM_AW-1:0]       ram_idx;
  logic [DATA_WIDTH-1:0]   rd_val;
  logic [NUM_SWITCHES-1:0] rise, clr, capture_d;

  assign ram_hit   = (address < RAM_END);
  assign ram_idx   = address[RAM_AW-1:0];
  assign wr_led    = we && (address == A_LED);
  assign wr_cap    = we && (address == A_CAP);
  assign wr_mask   = we && (address == A_MASK);
  assign warm_done = (warm_q == WARM_W'(WARMUP));

  assign rise      = status_q & ~status_prev_q & {NUM_SWITCHES{warm_done}};
  assign clr       = wr_cap ? data_fromCPU[NUM_SWITCHES-1:0] : '0;
  // A new edge wins over a simultaneous write-1-to-clear of the same bit.
  assign capture_d = (capture_q & ~clr) | rise;

  always_comb begin
    rd_val = '0;
    if (ram_hit)                rd_val = mem_q[ram_idx];
    else if (address == A_LED)  rd_val[NUM_LEDS-1:0] = leds_q;
    else if (address == A_STAT) rd_val[NUM_SWITCHES-1:0] = status_q;
    else if (address == A_CAP)  rd_val[NUM_SWITCHES-1:0] = capture_q;
    else if (address == A_MASK) rd_val[NUM_SWITCHES-1:0] = mask_q;
  end

  always_ff @(posedge clock) begin
    if (!reset && we && ram_hit) mem_q[ram_idx] <= data_fromCPU;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q       <= '0;
      ready_q       <= 1'b0;
      leds_q        <= '0;
      sync_q        <= '0;
      status_prev_q <= '0;
      capture_q     <= '0;
      mask_q        <= '0;
      warm_q        <= '0;
    end else begin
      ready_q       <= we | re;
      if (re && !we) rdata_q <= rd_val;
      if (wr_led)    leds_q  <= data_fromCPU[NUM_LEDS-1:0];
      if (wr_mask)   mask_q  <= data_fromCPU[NUM_SWITCHES-1:0];
      sync_q        <= switches;
      status_prev_q <= status_q;
      capture_q     <= capture_d;
      if (!warm_done) warm_q <= warm_q + WARM_W'(1);
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [NUM_SWITCHES-1:0] sync2_q;
  logic [DB_W-1:0]         db_cnt_q [NUM_SWITCHES];

  // Status flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync2_q  <= '0;
      status_q <= '0;
      for (int i = 0; i < NUM_SWITCHES; i++) db_cnt_q[i] <= '0;
    end else begin
      sync2_q <= sync_q;
      for (int i = 0; i < NUM_SWITCHES; i++) begin
        if (sync2_q[i] != status_q[i]) begin
          if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            status_q[i] <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end
`else
  // status_q is the second synchroniser stage.
  always_ff @(posedge clock) begin
    if (reset) status_q <= '0;
    else       status_q <= sync_q;
  end
`endif

  assign data_toCPU = rdata_q;
  assign ready      = ready_q;
  assign LEDs       = leds_q;
  assign sw_irq     = |(capture_q & mask_q);

endmodule

// File: tb/tb_mmio_controller.sv
// Directed checks of mmio_controller: RAM/LED access, ready timing, switch edge/irq, reset handling.
module tb_mmio_controller;
  logic        clock, reset, we, re, ready, sw_irq;
  logic [15:0] address;
  logic [31:0] data_fromCPU, data_toCPU;
  logic [3:0]  LEDs, switches;
  int          vectors = 0;
  int          miscompares = 0;

`ifdef SWITCH_DEBOUNCE_EN
  localparam int SW_LAT = 19;
`else
  localparam int SW_LAT = 3;
`endif

  mmio_controller dut (
    .clock(clock), .reset(reset), .address(address), .data_fromCPU(data_fromCPU),
    .we(we), .re(re), .data_toCPU(data_toCPU), .ready(ready), .LEDs(LEDs),
    .switches(switches), .sw_irq(sw_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    address = a; data_fromCPU = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    address = a; re = 1'b1;
    tick();
    re = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; address = '0; data_fromCPU = '0; switches = '0;
    repeat (3) tick();
    chk("rst_leds",  32'(LEDs), 32'h0);
    chk("rst_data",  data_toCPU, 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_irq",   32'(sw_irq), 32'h0);
    reset = 1'b0;

    // RAM write then read
    wr(16'd5, 32'hDEADBEEF);
    chk("ram_wr_ready", 32'(ready), 32'h1);
    chk("ram_wr_data_hold", data_toCPU, 32'h0);
    tick();
    chk("ram_wr_ready_drop", 32'(ready), 32'h0);
    rd(16'd5);
    chk("ram_rd_ready", 32'(ready), 32'h1);
    chk("ram_rd_data", data_toCPU, 32'hDEADBEEF);
    tick();
    chk("ram_rd_ready_drop", 32'(ready), 32'h0);
    chk("ram_rd_data_hold", data_toCPU, 32'hDEADBEEF);

    // LED register
    wr(16'hFF00, 32'hFFFF_FFFA);
    chk("led_out", 32'(LEDs), 32'hA);
    rd(16'hFF00);
    chk("led_rd", data_toCPU, 32'h0000_000A);

    // Back-to-back write then read
    wr(16'd6, 32'h0000_1234);
    chk("b2b_wr_ready", 32'(ready), 32'h1);
    rd(16'd6);
    chk("b2b_rd_ready", 32'(ready), 32'h1);
    chk("b2b_rd_data", data_toCPU, 32'h0000_1234);

    // Unmapped read
    rd(16'd1025);
    chk("unmap_ready", 32'(ready), 32'h1);
    chk("unmap_data", data_toCPU, 32'h0);
    wr(16'hFF10, 32'hFFFF_FFFF);
    chk("unmap_wr_led", 32'(LEDs), 32'hA);

    // Simultaneous we/re acts as write only
    rd(16'd5);
    address = 16'd7; data_fromCPU = 32'h55AA_55AA; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    chk("wrrd_ready", 32'(ready), 32'h1);
    chk("wrrd_data_hold", data_toCPU, 32'hDEADBEEF);
    rd(16'd7);
    chk("wrrd_ram7", data_toCPU, 32'h55AA_55AA);

    // Switch edge capture and interrupt
    wr(16'hFF03, 32'h2);
    switches = 4'b0010;
    repeat (SW_LAT - 1) tick();
    chk("edge_early_irq", 32'(sw_irq), 32'h0);
    tick();
    chk("edge_irq", 32'(sw_irq), 32'h1);
    rd(16'hFF02);
    chk("edge_cap", data_toCPU, 32'h2);
    rd(16'hFF01);
    chk("edge_status", data_toCPU, 32'h2);
    wr(16'hFF02, 32'h2);
    chk("w1c_irq", 32'(sw_irq), 32'h0);
    rd(16'hFF02);
    chk("w1c_cap", data_toCPU, 32'h0);

    // Edge arriving in the same cycle as its clear
    switches = 4'b0000;
    repeat (SW_LAT + 1) tick();
    switches = 4'b0010;
    repeat (SW_LAT - 1) tick();
    wr(16'hFF02, 32'h2);
    chk("set_beats_clr_irq", 32'(sw_irq), 32'h1);
    switches = 4'b0011;
    repeat (SW_LAT) tick();
    rd(16'hFF02);
    chk("cap_two_bits", data_toCPU, 32'h3);

    // Reset during a pending read, switches held high through reset
    switches = 4'hF; reset = 1'b1; address = 16'd5; re = 1'b1;
    tick();
    re = 1'b0;
    chk("rst_rd_ready", 32'(ready), 32'h0);
    chk("rst_rd_data", data_toCPU, 32'h0);
    chk("rst_mid_leds", 32'(LEDs), 32'h0);
    chk("rst_mid_irq", 32'(sw_irq), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_no_ready", 32'(ready), 32'h0);
    repeat (SW_LAT + 3) tick();
    rd(16'hFF02);
    chk("warm_no_cap", data_toCPU, 32'h0);
    rd(16'hFF01);
    chk("warm_status", data_toCPU, 32'hF);
    rd(16'hFF03);
    chk("rst_mask", data_toCPU, 32'h0);

`ifdef SWITCH_DEBOUNCE_EN
    // Short pulse is filtered, long level passes after the debounce interval
    switches = 4'h0;
    wr(16'hFF03, 32'h1);
    repeat (SW_LAT + 6) tick();
    wr(16'hFF02, 32'hF);
    switches = 4'h1;
    repeat (10) tick();
    switches = 4'h0;
    repeat (30) tick();
    chk("db_pulse_irq", 32'(sw_irq), 32'h0);
    switches = 4'h1;
    repeat (SW_LAT - 1) tick();
    chk("db_level_early", 32'(sw_irq), 32'h0);
    tick();
    chk("db_level_irq", 32'(sw_irq), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
